// File: rtl/apu_pkg.sv
// apu_pkg: shared sound ids, sequencer state encoding and the note half-period table.
package apu_pkg;

    typedef enum logic [1:0] {
        SID_NONE = 2'd0,
        SID_EAT  = 2'd1,
        SID_HIT  = 2'd2,
        SID_DIE  = 2'd3
    } sound_id_e;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_PLAY = 1'b1;

    // Indexed by {sound_id, note}; 0 is a rest. Id 0 rows keep the idle output silent.
    localparam logic [15:0] HALF_TABLE [16] = '{
        16'd0,   16'd0,   16'd0,   16'd0,
        16'd100, 16'd80,  16'd0,   16'd60,
        16'd200, 16'd0,   16'd150, 16'd250,
        16'd300, 16'd400, 16'd500, 16'd600
    };

    function automatic logic [15:0] half_period(input logic [1:0] id, input logic [1:0] note);
        return HALF_TABLE[{id, note}];
    endfunction

endpackage

// File: rtl/apu_sequencer_if.sv
// apu_sequencer_if: request/frame inputs and audio/status outputs of the sequencer.
interface apu_sequencer_if;
    logic       frame_end;
    logic       eat_sound;
    logic       hit_sound;
    logic       die_sound;
    logic       sound;
    logic       busy;
    logic [1:0] sound_id;

    modport master (
        output frame_end, eat_sound, hit_sound, die_sound,
        input  sound, busy, sound_id
    );

    modport slave (
        input  frame_end, eat_sound, hit_sound, die_sound,
        output sound, busy, sound_id
    );
endinterface

// File: rtl/apu_tone_div.sv
// apu_tone_div: square-wave divider toggling every half_period clocks; 0 holds a rest.
// With APU_NOISE_EN an extra o_tick pulse marks each toggle.
module apu_tone_div #(
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_half_period,
`ifdef APU_NOISE_EN
    output logic         o_tick,
`endif
    output logic         o_sq
);
    logic [W-1:0] r_cnt;
    logic         r_sq;
    logic         w_rest;
    logic         w_zero;

    assign w_rest = i_half_period == '0;
    assign w_zero = r_cnt == '0;
    assign o_sq   = r_sq;

    // Counting half_period-1 down to 0 gives a toggle exactly every half_period clocks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_sq  <= 1'b0;
        end else if (i_load || w_rest) begin
            r_cnt <= w_rest ? '0 : i_half_period - W'(1);
            r_sq  <= 1'b0;
        end else if (w_zero) begin
            r_cnt <= i_half_period - W'(1);
            r_sq  <= ~r_sq;
        end else begin
            r_cnt <= r_cnt - W'(1);
        end
    end

`ifdef APU_NOISE_EN
    assign o_tick = !i_load && !w_rest && w_zero;
`endif
endmodule

// File: rtl/apu_sequencer.sv
// apu_sequencer: prioritised 4-note sound effect player driven by frame_end.
// Define APU_NOISE_EN to gate die notes with a 15-bit LFSR noise bit.
module apu_sequencer
    import apu_pkg::*;
#(
    parameter int HALF_W      = 12,
    parameter int NOTE_FRAMES = 4
) (
    input logic            clk,
    input logic            rst_n,
    apu_sequencer_if.slave bus
);
    logic [0:0]        r_state;
    logic [1:0]        r_id;
    logic [1:0]        r_note;
    logic [3:0]        r_frames;
    logic [2:0]        r_req;
    logic [2:0]        r_armed;
    logic [2:0]        w_req;
    logic [2:0]        w_rise;
    logic [1:0]        w_new_id;
    logic              w_start;
    logic              w_frame;
    logic              w_note_end;
    logic              w_last;
    logic [0:0]        w_state_nx;
    logic [1:0]        w_id_nx;
    logic [1:0]        w_note_nx;
    logic [3:0]        w_frames_nx;
    logic              w_load;
    logic [HALF_W-1:0] w_hp;
    logic              w_sq;

    assign w_req = {bus.die_sound, bus.hit_sound, bus.eat_sound};
    // A request must be seen low after reset before its rise counts, so a held level cannot retrigger.
    assign w_rise   = w_req & ~r_req & r_armed;
    assign w_new_id = w_rise[2] ? SID_DIE : w_rise[1] ? SID_HIT : w_rise[0] ? SID_EAT : SID_NONE;
    assign w_start  = (w_new_id != SID_NONE) && (w_new_id >= r_id);

    assign w_frame    = (r_state == ST_PLAY) && bus.frame_end;
    assign w_note_end = w_frame && (r_frames == 4'(NOTE_FRAMES - 1));
    assign w_last     = w_note_end && (r_note == 2'd3);

    assign w_state_nx  = w_start ? ST_PLAY : w_last ? ST_IDLE : r_state;
    assign w_id_nx     = w_start ? w_new_id : w_last ? SID_NONE : r_id;
    assign w_note_nx   = w_start ? 2'd0 : w_note_end ? r_note + 2'd1 : r_note;
    assign w_frames_nx = (w_start || w_note_end) ? 4'd0 : w_frame ? r_frames + 4'd1 : r_frames;
    assign w_load      = w_start || w_note_end;
    assign w_hp        = HALF_W'(half_period(w_id_nx, w_note_nx));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_id     <= SID_NONE;
            r_note   <= 2'd0;
            r_frames <= 4'd0;
            r_req    <= 3'd0;
            r_armed  <= 3'd0;
        end else begin
            r_state  <= w_state_nx;
            r_id     <= w_id_nx;
            r_note   <= w_note_nx;
            r_frames <= w_frames_nx;
            r_req    <= w_req;
            r_armed  <= r_armed | ~w_req;
        end
    end

`ifdef APU_NOISE_EN
    logic        w_tick;
    logic [14:0] r_lfsr;

    apu_tone_div #(.W(HALF_W)) u_tone (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_load       (w_load),
        .i_half_period(w_hp),
        .o_tick       (w_tick),
        .o_sq         (w_sq)
    );

    // x^15 + x^14 + 1, advanced once per tone toggle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_lfsr <= 15'h0001;
        else if (w_tick)
            r_lfsr <= {r_lfsr[13:0], r_lfsr[14] ^ r_lfsr[13]};
    end

    assign bus.sound = (r_state == ST_PLAY) && w_sq && ((r_id != SID_DIE) || r_lfsr[0]);
`else
    apu_tone_div #(.W(HALF_W)) u_tone (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_load       (w_load),
        .i_half_period(w_hp),
        .o_sq         (w_sq)
    );

    assign bus.sound = (r_state == ST_PLAY) && w_sq;
`endif

    assign bus.busy     = r_state == ST_PLAY;
    assign bus.sound_id = r_id;
endmodule

// File: doc/apu_sequencer.md
APU_SEQUENCER -- requirements
Module: apu_sequencer

Interface
REQ-001 SHALL have parameter HALF_W, default 12: width of the tone half-period counter in clk cycles.
REQ-002 SHALL have parameter NOTE_FRAMES, default 4: frames each note lasts (range 1..15).
REQ-003 SHALL have port clk, input, 1: system clock, the only clock.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-005 SHALL have port frame_end, input, 1: one-cycle pulse per video frame.
REQ-006 SHALL have port eat_sound, input, 1: level request, sheep eaten.
REQ-007 SHALL have port hit_sound, input, 1: level request, player hit.
REQ-008 SHALL have port die_sound, input, 1: level request, dragon killed.
REQ-009 SHALL have port sound, output, 1: square-wave audio bit to the output pin.
REQ-010 SHALL have port busy, output, 1: high while a sound plays.
REQ-011 SHALL have port sound_id, output, 2: 0 none, 1 eat, 2 hit, 3 die.

Function
REQ-012 SHALL register each request input and detect its rising edge (input high, registered copy low).
REQ-013 SHALL use priority die > hit > eat when several edges occur in the same cycle.
REQ-014 SHALL implement states IDLE and PLAY: IDLE->PLAY on any edge; PLAY->IDLE after the last note expires.
REQ-015 SHALL, on an edge of priority >= the current sound_id, restart at note 0 with the new id; lower-priority edges while busy SHALL be dropped.
REQ-016 SHALL set sound_id and busy on the cycle after the detected edge (latency 1).
REQ-017 SHALL play 4 notes per sound; note index advances on the NOTE_FRAMES-th frame_end counted within the note.
REQ-018 SHALL take each note's half-period from a constant table indexed by {sound_id, note}; value 0 means rest with sound held 0.
REQ-019 SHALL count the tone counter down each clk; at 0 SHALL reload the half-period and toggle sound.
REQ-020 SHALL, on each note start or restart, force sound to 0 and load the counter with the new half-period.
REQ-021 SHALL, when frame_end of the last note and a valid edge coincide, start the new sound; no IDLE cycle.
REQ-022 SHALL hold sound at 0 and sound_id at 0 in IDLE.
REQ-023 SHALL ignore frame_end in IDLE (no counting).

Reset
REQ-024 SHALL, while rst_n is low, force state IDLE, sound 0, busy 0, sound_id 0, all counters and edge registers 0.
REQ-025 SHALL abort a sound in progress when reset asserts mid-note; after release it SHALL not resume, and a request still held high SHALL not retrigger until it falls and rises again.

Configuration
REQ-026 SHALL support macro APU_NOISE_EN: when defined, die notes SHALL output sound = tone AND bit 0 of a 15-bit LFSR (x^15+x^14+1, seed 15'h0001), the LFSR stepping on every tone toggle.
REQ-027 SHALL, without APU_NOISE_EN, play die notes as plain square waves, with no LFSR logic synthesised.

Structure
REQ-028 SHALL place the sound_id encodings, the state encoding and the 16-entry half-period table in shared package apu_pkg.
REQ-029 SHALL implement the tone counter and toggle as sub-module apu_tone_div (inputs: load, half_period; output: square bit).

Verification
REQ-030 SHALL check: eat_sound rises at cycle 10 -> busy=1, sound_id=1 at cycle 11; 4 notes x NOTE_FRAMES frame_end pulses later busy=0, sound=0.
REQ-031 SHALL check: eat, hit and die rise in the same cycle -> sound_id=3 only.
REQ-032 SHALL check: eat playing, die rises in note 2 -> sound_id=3, note 0, sound=0 next cycle; a later eat edge -> ignored.
REQ-033 SHALL check: half-period 100 -> sound toggles every 100 clks; a rest entry -> sound stays 0 for the whole note.
REQ-034 SHALL check: rst_n low mid-hit while hit_sound stays high -> all outputs 0 immediately; after release no sound until hit_sound falls and rises again.
REQ-035 SHALL check: with APU_NOISE_EN, die note output differs from plain tone, and the LFSR is 15'h0001 after reset; without it, output matches plain tone.
